kara_term_gen_14bit: RTL and testbench

KARA_TERM_GEN_14BIT -- requirements
Module: kara_term_gen_14bit

---
 rtl/kara_term_gen_14bit.sv | 120 ++++++++++++
 tb/tb_kara_term_gen_14bit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/kara_term_gen_14bit.sv
`timescale 1ns/1ps
// Karatsuba term generator: one h x h carry-less multiplier shared over S_LO/S_HI/S_MID; result valid 3 clocks after accept.
// Results are held in DONE until out_ready, and a new pair can be accepted on the retiring edge.
module kara_term_gen_14bit #(
  parameter int n = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] a_in,
  input  logic [n-1:0] b_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-2:0] t_lo,
  output logic [n-2:0] t_mid,
  output logic [n-2:0] t_hi
);

  localparam int h = n / 2;

  typedef enum logic [2:0] {IDLE, S_LO, S_HI, S_MID, DONE} state_t;

  state_t       state;
  logic [n-1:0] a_reg;
  logic [n-1:0] b_reg;
  logic [h-1:0] mul_a;
  logic [h-1:0] mul_b;
  logic [n-2:0] prod;
  logic         accept;

  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // Operand steering for the single shared multiplier.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      S_LO: begin
        mul_a = a_reg[h-1:0];
        mul_b = b_reg[h-1:0];
      end
      S_HI: begin
        mul_a = a_reg[n-1:h];
        mul_b = b_reg[n-1:h];
      end
      S_MID: begin
        mul_a = a_reg[h-1:0] ^ a_reg[n-1:h];
        mul_b = b_reg[h-1:0] ^ b_reg[n-1:h];
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase
  end

  always_comb begin
    prod = '0;
    for (int i = 0; i < h; i++) begin
      if (mul_a[i]) begin
        prod = prod ^ ({{(n-1-h){1'b0}}, mul_b} << i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      t_lo      <= '0;
      t_mid     <= '0;
      t_hi      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg <= a_in;
            b_reg <= b_in;
            state <= S_LO;
          end
        end
        S_LO: begin
          t_lo  <= prod;
          state <= S_HI;
        end
        S_HI: begin
          t_hi  <= prod;
          state <= S_MID;
        end
        S_MID: begin
          // Middle term cross products = (a0^a1)(b0^b1) minus both outer terms.
          t_mid     <= prod ^ t_lo ^ t_hi;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              a_reg <= a_in;
              b_reg <= b_in;
              state <= S_LO;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kara_term_gen_14bit.sv
`timescale 1ns/1ps
// Bench for kara_term_gen_14bit: directed literal vectors, backpressure, mid-op reset, random run vs carry-less model.
module tb_kara_term_gen_14bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [13:0] a_in = '0;
  logic [13:0] b_in = '0;
  logic        in_ready;
  logic        out_valid;
  logic [12:0] t_lo;
  logic [12:0] t_mid;
  logic [12:0] t_hi;

  kara_term_gen_14bit #(.n(14)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_in     (a_in),
    .b_in     (b_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .t_lo     (t_lo),
    .t_mid    (t_mid),
    .t_hi     (t_hi)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: m_left = -1 idle, >0 clocks until result, 0 result held.
  int          m_left = -1;
  int          accepts = 0;
  logic [12:0] e_lo = '0;
  logic [12:0] e_mid = '0;
  logic [12:0] e_hi = '0;
  logic [26:0] e_full = '0;
  bit          chk_en = 1'b0;

  function automatic logic [26:0] clm(input logic [13:0] x, input logic [13:0] y);
    logic [26:0] r;
    r = '0;
    for (int i = 0; i < 14; i++)
      if (x[i]) r = r ^ ({13'b0, y} << i);
    return r;
  endfunction

  function automatic logic [12:0] clm7(input logic [6:0] x, input logic [6:0] y);
    logic [26:0] r;
    r = clm({7'b0, x}, {7'b0, y});
    return r[12:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit rdy;
    rdy = (m_left < 0) || (m_left == 0 && out_ready);
    if (!rst_n) begin
      m_left <= -1;
    end else if (in_valid && rdy) begin
      m_left  <= 3;
      e_lo    <= clm7(a_in[6:0], b_in[6:0]);
      e_hi    <= clm7(a_in[13:7], b_in[13:7]);
      e_mid   <= clm7(a_in[6:0], b_in[13:7]) ^ clm7(a_in[13:7], b_in[6:0]);
      e_full  <= clm(a_in, b_in);
      accepts <= accepts + 1;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
    end else if (m_left == 0 && out_ready) begin
      m_left <= -1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", out_valid, m_left == 0);
      chk("in_ready", in_ready, (m_left < 0) || (m_left == 0 && out_ready));
      if (m_left == 0) begin
        chk("t_lo", t_lo, e_lo);
        chk("t_mid", t_mid, e_mid);
        chk("t_hi", t_hi, e_hi);
        chk("overlap", {14'b0, t_lo} ^ ({14'b0, t_mid} << 7) ^ ({14'b0, t_hi} << 14), e_full);
      end
    end
  end

  task automatic send(input logic [13:0] a, input logic [13:0] b);
    int k;
    a_in = a;
    b_in = b;
    in_valid = 1'b1;
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      if (in_ready) break;
      k++;
    end
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    if (k >= 20) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #2;
      lat++;
    end
    if (!out_valid) chk("valid_timeout", 0, 1);
  endtask

  task automatic directed(input string name, input logic [13:0] a, input logic [13:0] b,
                          input logic [12:0] lo, input logic [12:0] mid, input logic [12:0] hi);
    int lat;
    send(a, b);
    wait_valid(lat);
    chk({name, "_latency"}, lat, 3);
    chk({name, "_lo"}, t_lo, lo);
    chk({name, "_mid"}, t_mid, mid);
    chk({name, "_hi"}, t_hi, hi);
  endtask

  initial begin
    int lat;
    int cyc;
    int start;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_t_lo", t_lo, 0);
    chk("rst_t_mid", t_mid, 0);
    chk("rst_t_hi", t_hi, 0);
    chk_en = 1'b1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    directed("v0003", 14'h0003, 14'h0003, 13'h0005, 13'h0000, 13'h0000);
    directed("v3fff_80", 14'h3FFF, 14'h0080, 13'h0000, 13'h007F, 13'h007F);
    directed("v0040", 14'h0040, 14'h0040, 13'h1000, 13'h0000, 13'h0000);
    directed("v2000", 14'h2000, 14'h2000, 13'h0000, 13'h0000, 13'h1000);
    directed("v3fff", 14'h3FFF, 14'h3FFF, 13'h1555, 13'h0000, 13'h1555);

    // Backpressure: hold result for 5 cycles, then retire and accept on the same edge.
    send(14'h1234, 14'h0567);
    wait_valid(lat);
    out_ready = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #2;
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    send(14'h2AAA, 14'h1555);
    wait_valid(lat);
    chk("bp_next_latency", lat, 3);

    // Reset while the multiplier is on the high term.
    send(14'h3C5A, 14'h2B71);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_t_lo", t_lo, 0);
    chk("midrst_t_mid", t_mid, 0);
    chk("midrst_t_hi", t_hi, 0);
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #2;
      chk("midrst_no_valid", out_valid, 0);
    end

    // Random traffic with random backpressure.
    start = accepts;
    cyc = 0;
    while ((accepts - start) < 2000 && cyc < 40000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a_in      = 14'($urandom);
      b_in      = 14'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #2;
      cyc++;
    end
    chk("random_budget", (accepts - start) >= 2000, 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
